sprite_rotate_scanner: RTL and testbench

- Consumes the 8-bit sprite rotate code driven by the sprite-rotate PIO.
- On each draw request, walks every destination pixel of a square 2^L x 2^L sprite in raster order.
- For each destination pixel it emits the rotated/flipped source ROM address to the sprite fetch stage over a valid/ready stream.
- Sits between the sprite-rotate PIO and the sprite ROM reader in the draw pipeline.

---
 rtl/sprite_rotate_scanner.sv | 167 ++++++++++++++++
 tb/tb_sprite_rotate_scanner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rotate_scanner.sv
// ============================================================================
// sprite_rotate_scanner
// ----------------------------------------------------------------------------
// Purpose:
//   Walks every destination pixel of a square 2^SIZE_LOG2 x 2^SIZE_LOG2 sprite
//   in raster order after each draw request. For each pixel it streams out the
//   source ROM address that realises the requested rotation/flip. The ROM
//   reader downstream consumes these beats over a valid/ready handshake.
//
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   rotate     - [1:0] quarter turns clockwise, [2] horizontal flip,
//                [3] vertical flip, [7:4] ignored
//   start      - one-cycle draw request, honoured only while idle
//   busy       - high while beats of the current draw are outstanding
//   done       - one-cycle pulse after the final beat is accepted
//   out_valid  - beat valid
//   out_ready  - downstream accepts beat
//   dst_x/y    - destination column/row of the current beat
//   src_addr   - source ROM address {src_y, src_x}
//   out_last   - marks the final beat (dst_x = dst_y = N-1)
//   abort      - (SPRITE_ROT_ABORT_EN only) abandon the current scan
//
// Build option:
//   SPRITE_ROT_ABORT_EN - when defined, adds the abort input.
// ============================================================================
module sprite_rotate_scanner #(
    parameter int SIZE_LOG2 = 5,
    parameter int ADDR_W    = 2 * SIZE_LOG2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           rotate,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIZE_LOG2-1:0] dst_x,
    output logic [SIZE_LOG2-1:0] dst_y,
    output logic [ADDR_W-1:0]    src_addr,
    output logic                 out_last
`ifdef SPRITE_ROT_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    localparam logic [SIZE_LOG2-1:0] MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SIZE_LOG2-1:0] x_q, x_d;
    logic [SIZE_LOG2-1:0] y_q, y_d;
    logic [3:0]           rot_q, rot_d;
    logic [ADDR_W-1:0]    src_q, src_d;

    logic xfer;
    logic lastBeat;
    logic abortReq;

    // The upper rotate bits are reserved; fold them into a deliberately unused net.
    logic unused_rotate;
    assign unused_rotate = ^rotate[7:4];

`ifdef SPRITE_ROT_ABORT_EN
    assign abortReq = abort;
`else
    assign abortReq = 1'b0;
`endif

    assign xfer     = (state_q == SCAN) && out_ready;
    assign lastBeat = (x_q == MAX) && (y_q == MAX);

    // Rotation first, then the optional flips act on the rotated source coordinates.
    function automatic logic [2*SIZE_LOG2-1:0] mapSrc(
        input logic [SIZE_LOG2-1:0] x,
        input logic [SIZE_LOG2-1:0] y,
        input logic [3:0]           r
    );
        logic [SIZE_LOG2-1:0] sx;
        logic [SIZE_LOG2-1:0] sy;
        case (r[1:0])
            2'd0:    begin sx = x;       sy = y;       end
            2'd1:    begin sx = y;       sy = MAX - x; end
            2'd2:    begin sx = MAX - x; sy = MAX - y; end
            default: begin sx = MAX - y; sy = x;       end
        endcase
        if (r[2]) sx = MAX - sx;
        if (r[3]) sy = MAX - sy;
        return {sy, sx};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic. Abort outranks completion of the final beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = SCAN;
            SCAN: begin
                if (abortReq)              state_d = IDLE;
                else if (xfer && lastBeat) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded purely from registered state so they stay stable under backpressure.
    always_comb begin
        busy      = (state_q == SCAN);
        out_valid = (state_q == SCAN);
        done      = (state_q == DONE);
        out_last  = (state_q == SCAN) && lastBeat;
    end

    // Counter/address next-state: the source address is computed from the
    // next coordinates so it lands in the same register stage as dst_x/dst_y.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        rot_d = rot_q;
        src_d = src_q;
        if ((state_q == IDLE) && start) begin
            rot_d = rotate[3:0];
            x_d   = '0;
            y_d   = '0;
            src_d = mapSrc('0, '0, rotate[3:0]);
        end else if (xfer) begin
            x_d = x_q + 1'b1;
            if (x_q == MAX) y_d = y_q + 1'b1;
            src_d = mapSrc(x_d, y_d, rot_q);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q   <= '0;
            y_q   <= '0;
            rot_q <= '0;
            src_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            rot_q <= rot_d;
            src_q <= src_d;
        end
    end

    assign dst_x    = x_q;
    assign dst_y    = y_q;
    assign src_addr = src_q;

endmodule

// File: tb/tb_sprite_rotate_scanner.sv
// ============================================================================
// tb_sprite_rotate_scanner
// ----------------------------------------------------------------------------
// Directed testbench for sprite_rotate_scanner at the default 32x32 size.
// Drives inputs on the falling edge and samples outputs on the falling edge.
// ============================================================================
module tb_sprite_rotate_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rotate;
    logic        start;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  dst_x;
    logic [4:0]  dst_y;
    logic [9:0]  src_addr;
    logic        out_last;
`ifdef SPRITE_ROT_ABORT_EN
    logic        abort;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    sprite_rotate_scanner dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rotate    (rotate),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dst_x     (dst_x),
        .dst_y     (dst_y),
        .src_addr  (src_addr),
        .out_last  (out_last)
`ifdef SPRITE_ROT_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Expected source address of raster beat k for a 4-bit rotate code.
    function automatic int expSrc(input logic [3:0] r, input int k);
        int x, y, sx, sy;
        x = k % 32;
        y = k / 32;
        case (r[1:0])
            2'd0:    begin sx = x;      sy = y;      end
            2'd1:    begin sx = y;      sy = 31 - x; end
            2'd2:    begin sx = 31 - x; sy = 31 - y; end
            default: begin sx = 31 - y; sy = x;      end
        endcase
        if (r[2]) sx = 31 - sx;
        if (r[3]) sy = 31 - sy;
        return sy * 32 + sx;
    endfunction

    // One-cycle start pulse with the given rotate code.
    task automatic applyStimulus(input logic [7:0] rot);
        @(negedge clk);
        rotate = rot;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Runs one complete draw, checking every beat, and reports selected beats.
    task automatic runScan(input logic [7:0] rot, input bit randomReady, input bit poke,
                           output int beats, output int busyCycles,
                           output int s0, output int s1, output int s32, output int sLast);
        int          k;
        bit          stalled;
        bit          finished;
        bit          pokeArmed;
        bit          pokeDone;
        logic [31:0] held;
        logic [31:0] nowVal;
        logic [3:0]  effRot;
        effRot     = rot[3:0];
        k          = 0;
        stalled    = 1'b0;
        finished   = 1'b0;
        pokeArmed  = 1'b0;
        pokeDone   = 1'b0;
        busyCycles = 0;
        held       = '0;
        s0 = -1; s1 = -1; s32 = -1; sLast = -1;
        out_ready  = 1'b1;
        applyStimulus(rot);
        for (int c = 0; c < 6000 && !finished; c++) begin
            if (c > 0) @(negedge clk);
            if (pokeArmed) begin
                start     = 1'b0;
                pokeArmed = 1'b0;
            end
            if (busy) busyCycles++;
            nowVal = {11'd0, out_last, dst_y, dst_x, src_addr};
            if (done) begin
                finished = 1'b1;
                checkOutput("done_busy", {31'd0, busy}, 32'd0);
                checkOutput("done_valid", {31'd0, out_valid}, 32'd0);
            end else if (out_valid) begin
                if (stalled) checkOutput("stall_hold", nowVal, held);
                checkOutput("src_addr", {22'd0, src_addr}, expSrc(effRot, k));
                checkOutput("dst_x", {27'd0, dst_x}, k % 32);
                checkOutput("dst_y", {27'd0, dst_y}, k / 32);
                checkOutput("out_last", {31'd0, out_last}, (k == 1023) ? 32'd1 : 32'd0);
                if (k == 0)    s0    = int'(src_addr);
                if (k == 1)    s1    = int'(src_addr);
                if (k == 32)   s32   = int'(src_addr);
                if (k == 1023) sLast = int'(src_addr);
                if (poke && !pokeDone && k == 200) begin
                    rotate    = 8'h02;
                    start     = 1'b1;
                    pokeArmed = 1'b1;
                    pokeDone  = 1'b1;
                end
                out_ready = randomReady ? ($urandom_range(0, 1) != 0) : 1'b1;
                if (out_ready) begin
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = nowVal;
                end
            end else begin
                checkOutput("valid_in_scan", {31'd0, out_valid}, 32'd1);
            end
        end
        if (!finished) begin
            checkOutput("scan_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            checkOutput("done_width", {31'd0, done}, 32'd0);
        end
        out_ready = 1'b1;
        beats     = k;
    endtask

    initial begin
        int beats, busyCycles, s0, s1, s32, sLast;
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        rotate    = 8'h00;
`ifdef SPRITE_ROT_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_last", {31'd0, out_last}, 32'd0);
        checkOutput("rst_src", {22'd0, src_addr}, 32'd0);
        checkOutput("rst_dst", {22'd0, dst_y, dst_x}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] identity scan");
        runScan(8'h00, 1'b0, 1'b0, beats, busyCycles, s0, s1, s32, sLast);
        checkOutput("r0_beats", beats, 1024);
        checkOutput("r0_busy_cycles", busyCycles, 1024);
        checkOutput("r0_first", s0, 0);
        checkOutput("r0_last", sLast, 1023);

        $display("[TB] quarter turn");
        runScan(8'h01, 1'b0, 1'b0, beats, busyCycles, s0, s1, s32, sLast);
        checkOutput("r1_beat0", s0, 992);
        checkOutput("r1_beat1", s1, 960);
        checkOutput("r1_beat32", s32, 993);

        $display("[TB] half turn");
        runScan(8'h02, 1'b0, 1'b0, beats, busyCycles, s0, s1, s32, sLast);
        checkOutput("r2_beat0", s0, 1023);
        checkOutput("r2_last", sLast, 0);

        runScan(8'h03, 1'b0, 1'b0, beats, busyCycles, s0, s1, s32, sLast);
        checkOutput("r3_beat0", s0, 31);
        runScan(8'h04, 1'b0, 1'b0, beats, busyCycles, s0, s1, s32, sLast);
        checkOutput("hflip_beat0", s0, 31);
        runScan(8'h08, 1'b0, 1'b0, beats, busyCycles, s0, s1, s32, sLast);
        checkOutput("vflip_beat0", s0, 992);
        runScan(8'hF0, 1'b0, 1'b0, beats, busyCycles, s0, s1, s32, sLast);
        checkOutput("reserved_beat0", s0, 0);
        checkOutput("reserved_last", sLast, 1023);

        $display("[TB] backpressure with quarter turn");
        runScan(8'h01, 1'b1, 1'b0, beats, busyCycles, s0, s1, s32, sLast);
        checkOutput("bp_beats", beats, 1024);
        checkOutput("bp_beat32", s32, 993);

        $display("[TB] mid-scan rotate change and start pulse");
        runScan(8'h00, 1'b0, 1'b1, beats, busyCycles, s0, s1, s32, sLast);
        checkOutput("poke_beats", beats, 1024);
        checkOutput("poke_busy_cycles", busyCycles, 1024);
        checkOutput("poke_last", sLast, 1023);

        $display("[TB] reset mid-scan");
        applyStimulus(8'h00);
        repeat (500) @(negedge clk);
        checkOutput("pre_reset_src", {22'd0, src_addr}, 32'd500);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
        checkOutput("mid_rst_src", {22'd0, src_addr}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_done", {31'd0, done}, 32'd0);
        checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(8'h00);
        checkOutput("restart_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("restart_src", {22'd0, src_addr}, 32'd0);
        checkOutput("restart_dst", {22'd0, dst_y, dst_x}, 32'd0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef SPRITE_ROT_ABORT_EN
        $display("[TB] abort mid-scan");
        applyStimulus(8'h01);
        repeat (100) @(negedge clk);
        checkOutput("pre_abort_src", {22'd0, src_addr}, expSrc(4'h1, 100));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        checkOutput("abort_no_done", {31'd0, done}, 32'd0);
        checkOutput("abort_idle", {31'd0, out_valid}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
